// File: rtl/drain_deskew_fifo_if.sv
// Drain-side bus of the deskew FIFO: skewed per-column input beats and the
// aligned, tagged row output with its status flags.
interface drain_deskew_fifo_if #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(DEPTH + 1);

  logic [N-1:0]        in_valid_i;
  logic [N*DATA_W-1:0] in_data_i;
  logic                in_ready_o;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [N*DATA_W-1:0] out_data_o;
  logic [RW-1:0]       out_row_o;
  logic                out_last_o;
  logic [CW-1:0]       count_o;
  logic                overflow_o;
  logic                skew_err_o;

  // Producer/consumer side (systolic array drain and memory writer)
  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_row_o, out_last_o,
           count_o, overflow_o, skew_err_o
  );

  // Deskew FIFO side
  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_row_o, out_last_o,
           count_o, overflow_o, skew_err_o
  );
endinterface

// File: rtl/drain_deskew_fifo.sv
// Realigns the column-skewed drain wavefront of the systolic array into full
// rows, tags each row with its index in the tile and buffers rows in a
// circular FIFO with valid/ready backpressure and sticky error flags.
module drain_deskew_fifo #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  drain_deskew_fifo_if.slave  dd_bus
);
  localparam int RW  = $clog2(N);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int RWD = N * DATA_W;

  logic [N-1:0]              w_al_valid;
  logic [N-1:0][DATA_W-1:0]  w_al_data;
  logic [RWD-1:0]            w_al_row;

  logic [RWD-1:0] r_mem [DEPTH];
  logic [RW-1:0]  r_tag [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  r_inflight;
  logic [RW-1:0]  r_rowcnt;
  logic           r_overflow;
  logic           r_skew_err;

  logic           w_a;
  logic           w_admit;
  logic           w_skew;
  logic           w_out_valid;
  logic           w_full;
  logic           w_pop;
  logic           w_push;
  logic           w_drop;
  logic [CW:0]    w_occ;

  // Circular pointer advance that wraps at DEPTH (DEPTH need not be a power of two)
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  genvar gc;
  generate
    for (gc = 0; gc < N - 1; gc++) begin : g_dly
      localparam int STG = N - 1 - gc;
      logic [STG-1:0]    r_v;
      logic [DATA_W-1:0] r_d [STG];

      // Column gc shifts through N-1-gc stages so it lines up with column N-1
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_v <= '0;
          for (int s = 0; s < STG; s++) r_d[s] <= '0;
        end else if (flush_i) begin
          r_v <= '0;
          for (int s = 0; s < STG; s++) r_d[s] <= '0;
        end else begin
          r_v[0] <= dd_bus.in_valid_i[gc];
          r_d[0] <= dd_bus.in_data_i[gc*DATA_W +: DATA_W];
          for (int s = 1; s < STG; s++) begin
            r_v[s] <= r_v[s-1];
            r_d[s] <= r_d[s-1];
          end
        end
      end

      assign w_al_valid[gc] = r_v[STG-1];
      assign w_al_data[gc]  = r_d[STG-1];
    end
  endgenerate

  // The last column arrives already aligned with the rest of its row
  assign w_al_valid[N-1] = dd_bus.in_valid_i[N-1];
  assign w_al_data[N-1]  = dd_bus.in_data_i[(N-1)*DATA_W +: DATA_W];
  assign w_al_row        = w_al_data;

  assign w_a         = w_al_valid[0];
  assign w_admit     = dd_bus.in_valid_i[0];
  assign w_skew      = |(w_al_valid ^ {N{w_a}});
  assign w_out_valid = (r_count != CW'(0));
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = w_out_valid && dd_bus.out_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_push      = w_a && (!w_full || w_pop);
  assign w_drop      = w_a && w_full && !w_pop;
  assign w_occ       = {1'b0, r_count} + {1'b0, r_inflight};

  // Row storage: write the aligned row and its tile-row tag at the tail
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (!flush_i && w_push) begin
      r_mem[r_tail] <= w_al_row;
      r_tag[r_tail] <= r_rowcnt;
    end else begin
      r_mem[r_tail] <= r_mem[r_tail];
      r_tag[r_tail] <= r_tag[r_tail];
    end
  end

  // Pointers, occupancy, in-flight rows, row tag counter and sticky flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_rowcnt   <= '0;
      r_overflow <= 1'b0;
      r_skew_err <= 1'b0;
    end else if (flush_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_rowcnt   <= '0;
      r_overflow <= 1'b0;
      r_skew_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail   <= ptr_inc(r_tail);
        r_rowcnt <= (r_rowcnt == RW'(N - 1)) ? RW'(0) : r_rowcnt + RW'(1);
      end
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A row stays in flight from its column-0 beat until its push slot
      case ({w_admit, w_a})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
      r_overflow <= r_overflow | w_drop;
      r_skew_err <= r_skew_err | w_skew;
    end
  end

  assign dd_bus.in_ready_o  = (w_occ < (CW+1)'(DEPTH));
  assign dd_bus.out_valid_o = w_out_valid;
  assign dd_bus.out_data_o  = r_mem[r_head];
  assign dd_bus.out_row_o   = r_tag[r_head];
  assign dd_bus.out_last_o  = w_out_valid && (r_tag[r_head] == RW'(N - 1));
  assign dd_bus.count_o     = r_count;
  assign dd_bus.overflow_o  = r_overflow;
  assign dd_bus.skew_err_o  = r_skew_err;
endmodule

// File: tb/tb_drain_deskew_fifo.sv
// Directed bench for drain_deskew_fifo (N=4, DATA_W=16, DEPTH=8): skews rows
// onto the drain inputs and checks aligned rows against an expected queue.
module tb_drain_deskew_fifo;
  localparam int N = 4;
  localparam int DW = 16;
  localparam int DEPTH = 8;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush = 1'b0;
  logic        rdy = 1'b0;
  logic [3:0]  tb_in_valid = 4'h0;
  logic [63:0] tb_in_data = 64'h0;

  bit          h_v [N];
  int          h_rid [N];
  logic [3:0]  h_m [N];
  exp_t        exp_q [$];
  int          m_rowcnt = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          launched;

  drain_deskew_fifo_if #(.N(N), .DATA_W(DW), .DEPTH(DEPTH)) dd ();

  drain_deskew_fifo #(.N(N), .DATA_W(DW), .DEPTH(DEPTH)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .flush_i(flush),
    .dd_bus (dd)
  );

  assign dd.in_valid_i  = tb_in_valid;
  assign dd.in_data_i   = tb_in_data;
  assign dd.out_ready_i = rdy;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] row_val(input int rid, input logic [3:0] mask);
    logic [63:0] w;
    w = 64'h0;
    for (int c = 0; c < N; c++)
      if (mask[c]) w[c*DW +: DW] = 16'(16 * rid + c);
    return w;
  endfunction

  // Column c of the row launched c cycles ago is on the bus this cycle
  task automatic drive_inputs();
    for (int c = 0; c < N; c++) begin
      if (h_v[c] && h_m[c][c]) begin
        tb_in_valid[c] = 1'b1;
        tb_in_data[c*DW +: DW] = 16'(16 * h_rid[c] + c);
      end else begin
        tb_in_valid[c] = 1'b0;
        tb_in_data[c*DW +: DW] = 16'h0;
      end
    end
  endtask

  task automatic clear_upstream();
    for (int a = 0; a < N; a++) begin
      h_v[a] = 1'b0;
      h_rid[a] = 0;
      h_m[a] = 4'h0;
    end
    exp_q.delete();
    m_rowcnt = 0;
  endtask

  // One clock cycle: score a pop, optionally launch a row, advance the clock
  task automatic tick(input bit launch, input int rid, input logic [3:0] mask, input bit store);
    exp_t e;
    if (!flush && rdy && dd.out_valid_o) begin
      if (exp_q.size() == 0) begin
        check_eq("stale_pop", dd.out_valid_o, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check_eq("row_data", dd.out_data_o, e.data);
        check_eq("row_tag", dd.out_row_o, e.tag);
        check_eq("row_last", dd.out_last_o, e.tag == 2'd3);
      end
    end
    if (launch && store) begin
      e.data = row_val(rid, mask);
      e.tag = 2'(m_rowcnt);
      exp_q.push_back(e);
      m_rowcnt = (m_rowcnt + 1) % N;
    end
    for (int a = N - 1; a > 0; a--) begin
      h_v[a] = h_v[a-1];
      h_rid[a] = h_rid[a-1];
      h_m[a] = h_m[a-1];
    end
    h_v[0] = launch;
    h_rid[0] = rid;
    h_m[0] = mask;
    if (flush) clear_upstream();
    drive_inputs();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 4'h0, 1'b0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick(1'b0, 0, 4'h0, 1'b0);
    flush = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_in_ready"}, dd.in_ready_o, 1'b1);
    check_eq({tag, "_out_valid"}, dd.out_valid_o, 1'b0);
    check_eq({tag, "_out_data"}, dd.out_data_o, 64'h0);
    check_eq({tag, "_out_row"}, dd.out_row_o, 2'd0);
    check_eq({tag, "_out_last"}, dd.out_last_o, 1'b0);
    check_eq({tag, "_count"}, dd.count_o, 4'd0);
    check_eq({tag, "_overflow"}, dd.overflow_o, 1'b0);
    check_eq({tag, "_skew_err"}, dd.skew_err_o, 1'b0);
  endtask

  initial begin
    clear_upstream();
    drive_inputs();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Single tile: rows appear at t0+4..t0+7 with tags 0..3
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(i < 4, i, 4'hF, i < 4);
      check_eq($sformatf("tile_valid_t%0d", i + 1), dd.out_valid_o, (i >= 3) && (i <= 6));
    end
    check_eq("tile_drained", exp_q.size(), 0);

    // Backpressure: admission stops at 8 rows, drain resumes in order
    rdy = 1'b0;
    launched = 0;
    for (int i = 0; i < 40; i++) begin
      rdy = (i >= 20);
      if (dd.in_ready_o && launched < 12) begin
        tick(1'b1, 16'h10 + launched, 4'hF, 1'b1);
        launched++;
      end else begin
        tick(1'b0, 0, 4'h0, 1'b0);
      end
      if (i < 20) check_eq($sformatf("bp_in_ready_%0d", i), dd.in_ready_o, i < 7);
      if (i == 19) check_eq("bp_count_full", dd.count_o, 4'd8);
    end
    check_eq("bp_launched", launched, 12);
    check_eq("bp_drained", exp_q.size(), 0);
    check_eq("bp_overflow", dd.overflow_o, 1'b0);

    // Overflow: forced row into a full FIFO is dropped, flag is sticky
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) tick(1'b1, 16'h30 + i, 4'hF, 1'b1);
    idle(4);
    check_eq("ovf_count_full", dd.count_o, 4'd8);
    check_eq("ovf_in_ready", dd.in_ready_o, 1'b0);
    tick(1'b1, 16'h40, 4'hF, 1'b0);
    idle(2);
    check_eq("ovf_before", dd.overflow_o, 1'b0);
    idle(1);
    check_eq("ovf_set", dd.overflow_o, 1'b1);
    check_eq("ovf_count_kept", dd.count_o, 4'd8);
    rdy = 1'b1;
    idle(10);
    check_eq("ovf_drained", exp_q.size(), 0);
    check_eq("ovf_sticky", dd.overflow_o, 1'b1);
    do_flush();
    check_eq("ovf_flush_clear", dd.overflow_o, 1'b0);

    // Skew error: column 2 missing, row still pushed, flag sticky until flush
    rdy = 1'b1;
    tick(1'b1, 16'h50, 4'b1011, 1'b1);
    idle(2);
    check_eq("skew_before", dd.skew_err_o, 1'b0);
    idle(1);
    check_eq("skew_set", dd.skew_err_o, 1'b1);
    tick(1'b1, 16'h51, 4'hF, 1'b1);
    idle(6);
    check_eq("skew_sticky", dd.skew_err_o, 1'b1);
    check_eq("skew_drained", exp_q.size(), 0);
    do_flush();
    check_eq("skew_flush_clear", dd.skew_err_o, 1'b0);

    // Full boundary: push and pop together at count 8
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) tick(1'b1, 16'h60 + i, 4'hF, 1'b1);
    idle(4);
    check_eq("full_count", dd.count_o, 4'd8);
    tick(1'b1, 16'h68, 4'hF, 1'b1);
    idle(2);
    rdy = 1'b1;
    idle(1);
    rdy = 1'b0;
    check_eq("full_pushpop_count", dd.count_o, 4'd8);
    check_eq("full_pushpop_ovf", dd.overflow_o, 1'b0);
    rdy = 1'b1;
    idle(10);
    check_eq("full_drained", exp_q.size(), 0);
    launched = 0;
    for (int i = 0; i < 40; i++) begin
      if (dd.in_ready_o && launched < 20) begin
        tick(1'b1, 16'h70 + launched, 4'hF, 1'b1);
        launched++;
      end else begin
        tick(1'b0, 0, 4'h0, 1'b0);
      end
    end
    check_eq("wrap_launched", launched, 20);
    check_eq("wrap_drained", exp_q.size(), 0);

    // Flush with 3 stored and 2 in flight
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b1, 16'h90 + i, 4'hF, 1'b1);
    idle(1);
    check_eq("flush_pre_count", dd.count_o, 4'd3);
    do_flush();
    check_eq("flush_count", dd.count_o, 4'd0);
    check_eq("flush_valid", dd.out_valid_o, 1'b0);
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check_eq($sformatf("flush_no_stale_%0d", i), dd.out_valid_o, 1'b0);
    end
    check_eq("flush_skew", dd.skew_err_o, 1'b0);
    tick(1'b1, 16'hA0, 4'hF, 1'b1);
    idle(5);
    check_eq("flush_next_drained", exp_q.size(), 0);

    // Asynchronous reset mid-stream
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b1, 16'hB0 + i, 4'hF, 1'b1);
    check_eq("rst_pre_valid", dd.out_valid_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    clear_upstream();
    drive_inputs();
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check_eq($sformatf("rst_no_partial_%0d", i), dd.out_valid_o, 1'b0);
    end
    check_eq("rst_skew", dd.skew_err_o, 1'b0);
    tick(1'b1, 16'hC0, 4'hF, 1'b1);
    idle(5);
    check_eq("rst_next_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/drain_deskew_fifo.md
# drain_deskew_fifo

Parametrised successor to the drain array. It collects results leaving the systolic array's drain channel as a column-skewed wavefront and realigns each column by its own delay so that every output beat is one full matrix row. Aligned rows go into a DEPTH-row FIFO with a valid/ready output, so the memory writer can apply backpressure. The block also tags each row with its index within the tile and flags protocol errors. It sits between the systolic array drain outputs and the result write-back port.

## Interface
- `N`, default 4: systolic array dimension, i.e. columns per row and rows per tile (N ≥ 2).
- `DATA_W`, default 16: width of one result element.
- `DEPTH`, default 8: row FIFO capacity in rows. Must satisfy DEPTH ≥ N.
- `clk_i` in 1: single clock; all state changes on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `flush_i` in 1: synchronous clear of delay lines, FIFO, row counter and error flags.
- `in_valid_i` in N: per-column drain valid.
- `in_data_i` in N×DATA_W: per-column drain data.
- `in_ready_o` out 1: upstream may launch a new row (column 0) this cycle.
- `out_valid_o` out 1: FIFO head row is valid.
- `out_ready_i` in 1: consumer accepts the head row.
- `out_data_o` out N×DATA_W: head row; column c occupies bits [c*DATA_W +: DATA_W].
- `out_row_o` out clog2(N): row index of the head row within its tile.
- `out_last_o` out 1: head row is row N-1 of its tile.
- `count_o` out clog2(DEPTH+1): rows currently stored.
- `overflow_o` out 1: sticky; an aligned row arrived while the FIFO was full.
- `skew_err_o` out 1: sticky; the aligned per-column valids disagreed.

## Operation
- **Input skew.** Row r's column c arrives exactly c cycles after its column 0 (t0 = cycle of column 0).
- **Deskew.** Column c passes through N-1-c register stages, each enabled every cycle. Column N-1 is not registered. All columns of a row are aligned at cycle t0+N-1. Delay stages hold data and valid.
- **Alignment check.** In each cycle, let a = aligned valid of column 0.
  - If any aligned column valid differs from a, set `skew_err_o`.
  - If a=1, push the aligned row, regardless of the error.
- **Push.** Write the row and its tag (row counter value) at the tail. The row counter increments modulo N on each successful push.
- **Push when full.** If the FIFO is full and no pop happens in the same cycle, drop the row. Set `overflow_o`; the row counter does not advance.
- **Pop.** Occurs when `out_valid_o` && `out_ready_i`.
- **Simultaneous push and pop.**
  - When full, both are legal: the row is kept and `count_o` is unchanged.
  - When empty, the pushed row is not visible until the next cycle (no fall-through).
- **Admission control.** `in_ready_o` = (DEPTH − `count_o` − rows in flight in the delay lines) ≥ 1. A row is in flight from its column-0 arrival until its push. Upstream must not assert `in_valid_i[0]` while `in_ready_o` is 0. Later columns of an admitted row are always accepted.
- **Error flags.** Both flags clear only on reset or `flush_i`.
- **Flush.** `flush_i` has priority over push and pop in the same cycle. Rows in flight are discarded.
- **Storage.** The FIFO is a circular buffer with head/tail pointers that wrap at DEPTH, plus an occupancy counter.

## Timing
- **Reset values.** All outputs are 0 except `in_ready_o`, which is 1. `out_data_o` is 0 and `out_row_o` is 0. Reset clears the delay lines, pointers and row counter.
- **Reset mid-operation.** Reset is asynchronous. In-flight and stored rows are lost; no partial row is emitted after release.
- **Latency.** With the FIFO empty and `out_ready_i`=1, the row whose column 0 arrives at cycle t0 appears on `out_valid_o` at t0+N and is popped at the end of that cycle.
- **Throughput.** One row per cycle with no backpressure. Consecutive rows start on consecutive cycles.
- **Output stability.** `out_data_o`, `out_row_o` and `out_last_o` are registered/RAM-read outputs. They stay stable while `out_valid_o`=1 and `out_ready_i`=0.
- **Flag timing.**
  - `count_o` and `in_ready_o` update the cycle after the push/pop/admit event.
  - `overflow_o` and `skew_err_o` assert the cycle after the offending cycle.

## Test plan
- **Single tile.** N=4, DEPTH=8. Drive 4 rows with skew; row r, column c = 16*r+c. Expect rows 0x00..0x03, 0x10..0x13, 0x20..0x23, 0x30..0x33 at cycles t0+4..t0+7. Expect `out_row_o` = 0,1,2,3 and `out_last_o` only on the 4th row.
- **Backpressure.** Hold `out_ready_i`=0 and stream 12 rows while respecting `in_ready_o`. `in_ready_o` must drop once count plus in-flight rows reaches 8, and exactly 8 rows are stored. Release: the rows drain in order with tags 0,1,2,3,0,1,2,3, and `overflow_o` stays 0.
- **Overflow.** Fill 8 rows, hold `out_ready_i`=0, force one more row in while ignoring `in_ready_o`. Expect `overflow_o`=1, `count_o`=8, and the stored rows unchanged.
- **Skew error.** Drop `in_valid_i[2]` on one row. Expect `skew_err_o`=1 from t0+4 and the row still pushed; the flag stays high until `flush_i`.
- **Full boundary.** Simultaneous push and pop at `count_o`=8 keeps count 8 with no overflow. Run 20 rows through DEPTH=8 to confirm pointer wrap preserves order.
- **Flush and reset.** Assert `flush_i` with 3 rows stored and 2 in flight: the next cycle `count_o`=0, `out_valid_o`=0, no stale row is emitted, and the next row is tagged 0. Assert `rst_ni`=0 asynchronously mid-stream: all outputs return to their reset values immediately.
